// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. The side driving valid holds its
// payload stable until the transfer edge. dbg_state mirrors the
// responder FSM so checkers can observe it.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: word-addressed 32-bit storage
// with byte strobes, a programmable response delay and error reporting
// for misaligned or out-of-range addresses.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    // One-cycle hold-off after a response completes, so the next accept
    // lands no earlier than the cycle after the return to IDLE.
    logic        bubble;

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic [3:0]  lat_wstrb;

    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic        eff_we;
    logic [3:0]  eff_wstrb;
    logic [AW-1:0] idx;
    logic        addr_err;
    logic [31:0] rd_word;
    logic        accept;
    logic        enter_resp;
    logic        do_write;

    logic [31:0] rsp_rdata_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = (state == ST_IDLE) && !bubble && bus.req_valid;

    // With zero latency the response is formed on the accepting edge, so
    // the live request fields are used there; otherwise the latched copy.
    assign eff_addr  = (state == ST_IDLE) ? bus.req_addr  : lat_addr;
    assign eff_wdata = (state == ST_IDLE) ? bus.req_wdata : lat_wdata;
    assign eff_we    = (state == ST_IDLE) ? bus.req_we    : lat_we;
    assign eff_wstrb = (state == ST_IDLE) ? bus.req_wstrb : lat_wstrb;

    assign idx      = eff_addr[AW+1:2];
    assign addr_err = (eff_addr[1:0] != 2'b00) || (eff_addr[31:AW+2] != '0);
    assign rd_word  = mem[idx];

    assign enter_resp = (accept && (LATENCY == 0)) ||
                        ((state == ST_WAIT) && (cnt == 4'd1));

    // Reset wins: a write due on a reset edge is discarded.
    assign do_write = !rst && enter_resp && eff_we && !addr_err;

    assign bus.req_ready = (state == ST_IDLE) && !bubble;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.dbg_state = state;

    // Latch the request payload on accept; later req_* changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_we    <= bus.req_we;
            lat_wstrb <= bus.req_wstrb;
        end
    end

    // Storage: byte-lane write on the edge entering RESP; not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= eff_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            bubble      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bubble <= 1'b0;
                    if (accept) begin
                        if (LATENCY == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= LAT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        bubble      <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= addr_err;
                rsp_rdata_q <= (addr_err || eff_we) ? 32'd0 : rd_word;
            end
        end
    end

endmodule
